// File: rtl/lsu_port_arbiter.sv
// Round-robin arbiter sharing one load-store controller among NUM_REQ requesters.
// One transaction in flight; request fields are registered and held until the response handshake.
module lsu_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              rq_valid_i,
    output logic [NUM_REQ-1:0]              rq_ready_o,
    input  logic [NUM_REQ-1:0]              rq_wr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   rq_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   rq_wdata_i,
    output logic [NUM_REQ-1:0]              rs_valid_o,
    input  logic [NUM_REQ-1:0]              rs_ready_i,
    output logic [DATA_WIDTH-1:0]           rs_rdata_o,
    output logic                            rs_error_o,
    output logic                            ds_req_valid_o,
    input  logic                            ds_req_ready_i,
    output logic                            ds_req_wr_o,
    output logic [ADDR_WIDTH-1:0]           ds_req_addr_o,
    output logic [DATA_WIDTH-1:0]           ds_req_wdata_o,
    input  logic                            ds_resp_valid_i,
    output logic                            ds_resp_ready_o,
    input  logic [DATA_WIDTH-1:0]           ds_resp_rdata_i,
    input  logic                            ds_resp_error_i,
    output logic [IDW-1:0]                  grant_id_o,
    output logic                            busy_o,
    output logic [15:0]                     txn_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        grant_q;
    logic [15:0]           txn_count_q;
    logic                  req_wr_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;

    logic                  found;
    logic [IDW-1:0]        win;
    logic [IDW-1:0]        cand;
    logic                  accept;
    logic                  resp_hs;
    logic [IDW-1:0]        ptr_next;

    // Search ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && rq_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign ptr_next = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

    always_comb begin
        state_d         = state_q;
        rq_ready_o      = '0;
        ds_req_valid_o  = 1'b0;
        rs_valid_o      = '0;
        ds_resp_ready_o = 1'b0;
        rs_rdata_o      = '0;
        rs_error_o      = 1'b0;
        accept          = 1'b0;
        resp_hs         = 1'b0;
        case (state_q)
            S_IDLE: begin
                // rst_n gating keeps rq_ready low throughout reset even with requests pending.
                if (found && rst_n) begin
                    rq_ready_o = NUM_REQ'(1) << win;
                    accept     = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ds_req_valid_o = 1'b1;
                if (ds_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                rs_valid_o[grant_q] = ds_resp_valid_i;
                ds_resp_ready_o     = rs_ready_i[grant_q];
                rs_rdata_o          = ds_resp_rdata_i;
                rs_error_o          = ds_resp_error_i;
                if (ds_resp_valid_i && rs_ready_i[grant_q]) begin
                    resp_hs = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            txn_count_q <= '0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q     <= win;
                req_wr_q    <= rq_wr_i[win];
                req_addr_q  <= rq_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
                req_wdata_q <= rq_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
            end
            if (resp_hs) begin
                ptr_q       <= ptr_next;
                txn_count_q <= txn_count_q + 16'd1;
            end
        end
    end

    assign ds_req_wr_o    = req_wr_q;
    assign ds_req_addr_o  = req_addr_q;
    assign ds_req_wdata_o = req_wdata_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q != S_IDLE);
    assign txn_count_o    = txn_count_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter: table of full transactions plus hand-written
// backpressure, reset-in-flight and counter-wrap sequences.
module tb_lsu_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   rq_valid, rq_ready, rq_wr;
    logic [127:0] rq_addr, rq_wdata;
    logic [3:0]   rs_valid, rs_ready;
    logic [31:0]  rs_rdata;
    logic         rs_error;
    logic         ds_req_valid, ds_req_ready, ds_req_wr;
    logic [31:0]  ds_req_addr, ds_req_wdata;
    logic         ds_resp_valid, ds_resp_ready;
    logic [31:0]  ds_resp_rdata;
    logic         ds_resp_error;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  txn_count;

    lsu_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rq_valid_i      (rq_valid),
        .rq_ready_o      (rq_ready),
        .rq_wr_i         (rq_wr),
        .rq_addr_i       (rq_addr),
        .rq_wdata_i      (rq_wdata),
        .rs_valid_o      (rs_valid),
        .rs_ready_i      (rs_ready),
        .rs_rdata_o      (rs_rdata),
        .rs_error_o      (rs_error),
        .ds_req_valid_o  (ds_req_valid),
        .ds_req_ready_i  (ds_req_ready),
        .ds_req_wr_o     (ds_req_wr),
        .ds_req_addr_o   (ds_req_addr),
        .ds_req_wdata_o  (ds_req_wdata),
        .ds_resp_valid_i (ds_resp_valid),
        .ds_resp_ready_o (ds_resp_ready),
        .ds_resp_rdata_i (ds_resp_rdata),
        .ds_resp_error_i (ds_resp_error),
        .grant_id_o      (grant_id),
        .busy_o          (busy),
        .txn_count_o     (txn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  valid;
        int          w;
        logic        wr;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[14];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h0C0 + 32'h20 * i;
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'h11111111 * (i + 1);
    endfunction

    task automatic default_payload();
        for (int i = 0; i < 4; i++) begin
            rq_addr[i*32 +: 32]  = addr_of(i);
            rq_wdata[i*32 +: 32] = wdata_of(i);
        end
    endtask

    // Called just after a negedge with the arbiter IDLE; returns just after a negedge, IDLE again.
    task automatic txn(input vec_t v);
        logic [15:0] expc;
        rq_valid      = v.valid;
        rq_wr         = {4{v.wr}};
        rs_ready      = 4'hF;
        ds_req_ready  = 1'b0;
        ds_resp_valid = 1'b0;
        #1;
        chk("rq_ready_grant", rq_ready, 4'b0001 << v.w);
        chk("busy_idle", busy, 0);
        @(negedge clk);
        chk("ds_req_valid", ds_req_valid, 1);
        chk("rq_ready_issue", rq_ready, 0);
        chk("grant_id", grant_id, v.w);
        chk("ds_req_addr", ds_req_addr, addr_of(v.w));
        chk("ds_req_wdata", ds_req_wdata, wdata_of(v.w));
        chk("ds_req_wr", ds_req_wr, v.wr);
        ds_req_ready = 1'b1;
        @(negedge clk);
        ds_req_ready  = 1'b0;
        ds_resp_valid = 1'b1;
        ds_resp_rdata = v.rdata;
        ds_resp_error = v.err;
        expc          = txn_count + 16'd1;
        #1;
        chk("rs_valid", rs_valid, 4'b0001 << v.w);
        chk("rs_rdata", rs_rdata, v.rdata);
        chk("rs_error", rs_error, v.err);
        chk("ds_resp_ready", ds_resp_ready, 1);
        chk("ds_req_valid_wait", ds_req_valid, 0);
        @(negedge clk);
        ds_resp_valid = 1'b0;
        ds_resp_error = 1'b0;
        ds_resp_rdata = 32'h0;
        #1;
        chk("busy_after", busy, 0);
        chk("rs_valid_after", rs_valid, 0);
        chk("rs_rdata_after", rs_rdata, 0);
        chk("txn_count", txn_count, expc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        vec_t v;
        vecs[0]  = '{4'b0100, 2, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{4'b1111, 3, 1'b0, 1'b0, 32'h00000001};
        vecs[2]  = '{4'b1111, 0, 1'b0, 1'b0, 32'h10000000};
        vecs[3]  = '{4'b1111, 1, 1'b0, 1'b0, 32'h21000000};
        vecs[4]  = '{4'b1111, 2, 1'b1, 1'b0, 32'h00000000};
        vecs[5]  = '{4'b1111, 3, 1'b0, 1'b0, 32'h43000000};
        vecs[6]  = '{4'b1111, 0, 1'b0, 1'b1, 32'h54000000};
        vecs[7]  = '{4'b1111, 1, 1'b0, 1'b0, 32'h65000000};
        vecs[8]  = '{4'b1111, 2, 1'b0, 1'b0, 32'h76000000};
        vecs[9]  = '{4'b1111, 3, 1'b0, 1'b0, 32'h87000000};
        vecs[10] = '{4'b0100, 2, 1'b0, 1'b0, 32'h98000000};
        vecs[11] = '{4'b1010, 3, 1'b0, 1'b0, 32'hA9000000};
        vecs[12] = '{4'b1010, 1, 1'b1, 1'b0, 32'h00000000};
        vecs[13] = '{4'b1010, 3, 1'b0, 1'b0, 32'hCB000000};

        rst_n         = 1'b0;
        rq_valid      = 4'hF;
        rq_wr         = 4'h0;
        rs_ready      = 4'hF;
        ds_req_ready  = 1'b1;
        ds_resp_valid = 1'b1;
        ds_resp_rdata = 32'hFFFFFFFF;
        ds_resp_error = 1'b1;
        default_payload();
        #12;
        chk("rst_rq_ready", rq_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ds_req_valid", ds_req_valid, 0);
        chk("rst_ds_req_addr", ds_req_addr, 0);
        chk("rst_ds_req_wdata", ds_req_wdata, 0);
        chk("rst_ds_resp_ready", ds_resp_ready, 0);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_rs_rdata", rs_rdata, 0);
        chk("rst_rs_error", rs_error, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_txn_count", txn_count, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        rq_valid      = 4'h0;
        ds_req_ready  = 1'b0;
        ds_resp_valid = 1'b0;
        ds_resp_rdata = 32'h0;
        ds_resp_error = 1'b0;
        #1;

        // Single read, round-robin fairness, wrap-and-skip
        for (int i = 0; i < 14; i++) begin
            txn(vecs[i]);
        end
        chk("txn_count_table", txn_count, 14);

        rq_valid = 4'h0;
        #1;
        chk("no_req_ready", rq_ready, 0);
        @(negedge clk);
        chk("no_req_busy", busy, 0);

        // Hold under backpressure: requester 0 writes 0xAA to 0x40
        rq_addr[31:0]  = 32'h40;
        rq_wdata[31:0] = 32'hAA;
        rq_wr          = 4'b0001;
        rq_valid       = 4'b0001;
        #1;
        chk("bp_rq_ready", rq_ready, 4'b0001);
        @(negedge clk);
        rq_valid       = 4'h0;
        rq_addr[31:0]  = 32'hFFFF0000;
        rq_wdata[31:0] = 32'h55;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_issue_valid", ds_req_valid, 1);
            chk("bp_issue_addr", ds_req_addr, 32'h40);
            chk("bp_issue_wdata", ds_req_wdata, 32'hAA);
            chk("bp_issue_wr", ds_req_wr, 1);
            @(negedge clk);
        end
        ds_req_ready = 1'b1;
        @(negedge clk);
        ds_req_ready  = 1'b0;
        ds_resp_valid = 1'b1;
        ds_resp_rdata = 32'h0;
        rs_ready      = 4'b1110;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rs_valid == 4'b0001) hi++;
            chk("bp_rs_valid", rs_valid, 4'b0001);
            chk("bp_resp_ready_low", ds_resp_ready, 0);
            chk("bp_wait_addr", ds_req_addr, 32'h40);
            chk("bp_wait_wdata", ds_req_wdata, 32'hAA);
            @(negedge clk);
        end
        rs_ready = 4'hF;
        #1;
        if (rs_valid == 4'b0001) hi++;
        chk("bp_resp_ready_high", ds_resp_ready, 1);
        @(negedge clk);
        ds_resp_valid = 1'b0;
        #1;
        chk("bp_rs_valid_cycles", hi, 4);
        chk("bp_busy_after", busy, 0);
        chk("bp_txn_count", txn_count, 15);
        default_payload();
        rq_wr = 4'h0;

        // Reset while waiting for the response (ptr is now 1)
        rq_valid = 4'b0010;
        #1;
        chk("mr_rq_ready", rq_ready, 4'b0010);
        @(negedge clk);
        rq_valid     = 4'h0;
        ds_req_ready = 1'b1;
        @(negedge clk);
        ds_req_ready  = 1'b0;
        ds_resp_valid = 1'b1;
        rs_ready      = 4'h0;
        #1;
        chk("mr_pre_rs_valid", rs_valid, 4'b0010);
        chk("mr_pre_busy", busy, 1);
        rst_n    = 1'b0;
        rq_valid = 4'hF;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_ds_req_valid", ds_req_valid, 0);
        chk("mr_rs_valid", rs_valid, 0);
        chk("mr_rq_ready", rq_ready, 0);
        chk("mr_txn_count", txn_count, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        ds_resp_valid = 1'b0;
        rs_ready      = 4'hF;
        #1;
        chk("mr_first_grant", rq_ready, 4'b0001);
        @(negedge clk);
        rq_valid = 4'h0;
        chk("mr_grant_id", grant_id, 0);
        chk("mr_busy_after", busy, 1);
        ds_req_ready = 1'b1;
        @(negedge clk);
        ds_req_ready  = 1'b0;
        ds_resp_valid = 1'b1;
        @(negedge clk);
        ds_resp_valid = 1'b0;
        #1;
        chk("mr_txn_count_after", txn_count, 1);

        // Counter wrap: preload near the top, then run two transactions
        force dut.txn_count_q = 16'hFFFE;
        #1;
        release dut.txn_count_q;
        @(negedge clk);
        #1;
        v = '{4'b0001, 0, 1'b0, 1'b0, 32'h12345678};
        txn(v);
        chk("wrap_ffff", txn_count, 16'hFFFF);
        v = '{4'b0010, 1, 1'b0, 1'b0, 32'h9ABCDEF0};
        txn(v);
        chk("wrap_zero", txn_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_port_arbiter.md
# lsu_port_arbiter

Round-robin arbiter that shares one load-store controller among `NUM_REQ` requesters, such as the fetch, load/store and DMA ports. It accepts one request at a time and registers it. It presents the registered request on the controller's valid/ready request port. It holds address and write data stable until the controller's response handshake completes, then routes that response back to the granted requester only. It sits between the requester masters and `load_store_controller`. That controller samples `req_addr`/`req_wdata` combinationally after its own accept, so the hold rule below is mandatory.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8, need not be a power of two.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `IDW`, `$clog2(NUM_REQ)`: requester-id width, derived.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rq_valid`  in  NUM_REQ  per-requester request valid
- `rq_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `rq_wr`  in  NUM_REQ  per-requester 1=write, 0=read
- `rq_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `rq_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `rs_valid`  out  NUM_REQ  per-requester response valid, one-hot or zero
- `rs_ready`  in  NUM_REQ  per-requester response ready
- `rs_rdata`  out  DATA_WIDTH  response data, shared by all requesters
- `rs_error`  out  1  response error, shared by all requesters
- `ds_req_valid`  out  1  request valid to controller
- `ds_req_ready`  in  1  request ready from controller
- `ds_req_wr`  out  1  registered request type
- `ds_req_addr`  out  ADDR_WIDTH  registered request address
- `ds_req_wdata`  out  DATA_WIDTH  registered request write data
- `ds_resp_valid`  in  1  controller response valid
- `ds_resp_ready`  out  1  response ready to controller
- `ds_resp_rdata`  in  DATA_WIDTH  controller response data
- `ds_resp_error`  in  1  controller response error
- `grant_id`  out  IDW  id of current or last granted requester
- `busy`  out  1  transaction in flight, i.e. state is not IDLE
- `txn_count`  out  16  completed transactions, wraps 0xFFFF->0

## Operation
- **States:**
  - IDLE → ISSUE on `rq_valid[w] && rq_ready[w]`.
  - ISSUE → WAIT_RESP on `ds_req_valid && ds_req_ready`.
  - WAIT_RESP → IDLE on `ds_resp_valid && ds_resp_ready`.
  - Illegal encodings → IDLE.
- **Arbitration (IDLE only):**
  - Winner w is the first i with `rq_valid[i]`, searching ptr, ptr+1, … modulo NUM_REQ.
  - `rq_ready` is one-hot at w, and all-zero if no `rq_valid` bit is set.
  - Arbitration is recomputed every cycle, so a requester may drop valid before it is accepted.
- **On accept:**
  - Latch `rq_wr[w]`, `rq_addr` slice w and `rq_wdata` slice w into the `ds_req_*` registers.
  - Set `grant_id` = w.
- **Hold rule:** `ds_req_wr`/`ds_req_addr`/`ds_req_wdata` must not change between accept and the response handshake.
- **ISSUE:** `ds_req_valid` = 1. All `rq_ready` = 0.
- **WAIT_RESP:**
  - `rs_valid[grant_id]` = `ds_resp_valid`; all other `rs_valid` bits are 0.
  - `ds_resp_ready` = `rs_ready[grant_id]`.
  - `rs_rdata` = `ds_resp_rdata`; `rs_error` = `ds_resp_error`. These are combinational pass-through, valid only while in WAIT_RESP and 0 otherwise.
  - `rs_ready` bits of non-granted requesters are ignored.
- **On response handshake:** ptr ← (grant_id+1) modulo NUM_REQ, wrapping from NUM_REQ-1 to 0. `txn_count` increments by 1.
- **Write responses** pass through unchanged; the controller returns rdata 0 for writes.

## Timing
- **Reset values:**
  - State IDLE; ptr 0; `grant_id` 0; `txn_count` 0.
  - `ds_req_valid`, `ds_req_wr`, `ds_req_addr`, `ds_req_wdata`, `ds_resp_ready`: 0.
  - `rs_valid`, `rs_rdata`, `rs_error`, `busy`: 0.
  - `rq_ready` is forced to 0 while `rst_n` is low.
- **Reset asserted mid-transaction:** the arbiter returns to IDLE immediately. No response is delivered, and the in-flight transaction is not counted.
- **Latency:**
  - Request accepted at edge N.
  - `ds_req_valid` high in cycle N+1.
  - Response is zero added latency, combinational from `ds_resp_valid`.
- **Next accept:** the earliest is the cycle after the response handshake; no pipelining. Per-transaction overhead over the controller is 2 cycles (IDLE accept + ISSUE).
- **Backpressure:**
  - `ds_req_ready` low keeps ISSUE with all `ds_req_*` outputs stable.
  - `rs_ready[grant_id]` low keeps WAIT_RESP with `ds_resp_ready` low.
- **Simultaneous requests:** a single grant per IDLE cycle; losers see `rq_ready` = 0 and must hold their request.

## Test plan
- **Single read:** reset, then requester 2 reads 0x100; controller returns 0xDEADBEEF. Required: `rq_ready` = 4'b0100 for one cycle, `ds_req_addr` = 0x100, `rs_valid` = 4'b0100 with `rs_rdata` = 0xDEADBEEF, `txn_count` = 1, ptr = 3.
- **Round-robin fairness:** all 4 requesters hold valid continuously for 8 transactions. Required grant order 0,1,2,3,0,1,2,3, with `busy` never low for more than 1 cycle between transactions.
- **Wrap and skip:** ptr = 3, only requesters 1 and 3 valid. Required grant order 3,1,3.
- **Hold under backpressure:** requester 0 writes 0xAA to 0x40. Hold `ds_req_ready` low 5 cycles, then `rs_ready[0]` low 3 cycles. Required: `ds_req_addr`/`ds_req_wdata` stable throughout, `rs_valid[0]` high for 4 cycles, no other `rs_valid` bit set.
- **Reset mid-operation:** assert `rst_n` low while in WAIT_RESP. Required: `busy`, `ds_req_valid`, `rs_valid` = 0 immediately; after release, first grant goes to requester 0; `txn_count` = 0.
- **Counter wrap:** preload via 65536 transactions. Required: `txn_count` reads 0 after the 65536th.
